// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC, issues I-cache reads, loads the IF/ID register, and hides
// I-cache miss latency. A redirect that arrives mid-miss is parked and
// applied once the miss completes; the late instruction is thrown away.

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_pc,
   input  logic        flush_ifid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ic_req,
   output logic [31:0] ic_addr,
   input  logic [31:0] ic_rdata,
   input  logic        ic_stall,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_inst,
   output logic        fetch_stall,
   output logic [15:0] miss_cycles
);

   // WAIT is a miss with nothing pending; SQUASH is a miss whose returning
   // word must be discarded because a redirect was seen while waiting.
   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      WAIT   = 2'd1,
      SQUASH = 2'd2
   } state_t;

   state_t      state_q,     state_d;
   logic [31:0] pc_q,        pc_d;
   logic [31:0] savedPc_q,   savedPc_d;
   logic        ifidValid_q, ifidValid_d;
   logic [31:0] ifidPc_q,    ifidPc_d;
   logic [31:0] ifidInst_q,  ifidInst_d;
   logic [15:0] missCycles_q, missCycles_d;
   logic [31:0] pcPlus4;

   assign pcPlus4 = pc_q + 32'd4;

   // Next-state logic: redirect beats flush beats stall on a delivered word;
   // during a miss the PC holds and only the parked redirect target changes.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      savedPc_d    = savedPc_q;
      ifidValid_d  = ifidValid_q;
      ifidPc_d     = ifidPc_q;
      ifidInst_d   = ifidInst_q;
      missCycles_d = missCycles_q;

      if (ic_stall && (missCycles_q != 16'hFFFF)) begin
         missCycles_d = missCycles_q + 16'd1;
      end

      case (state_q)
         FETCH, WAIT: begin
            if (ic_stall) begin
               if (redirect_valid) begin
                  savedPc_d = redirect_pc;
                  state_d   = SQUASH;
               end else begin
                  state_d   = WAIT;
               end
            end else begin
               state_d = FETCH;
               if (redirect_valid) begin
                  pc_d        = redirect_pc;
                  ifidValid_d = 1'b0;
                  ifidInst_d  = NOP;
               end else if (flush_ifid) begin
                  pc_d        = pcPlus4;
                  ifidValid_d = 1'b0;
                  ifidInst_d  = NOP;
               end else if (!stall_pc) begin
                  pc_d        = pcPlus4;
                  ifidValid_d = 1'b1;
                  ifidPc_d    = pc_q;
                  ifidInst_d  = ic_rdata;
               end
            end
         end

         SQUASH: begin
            if (ic_stall) begin
               if (redirect_valid) begin
                  savedPc_d = redirect_pc;
               end
            end else begin
               pc_d        = redirect_valid ? redirect_pc : savedPc_q;
               ifidValid_d = 1'b0;
               ifidInst_d  = NOP;
               state_d     = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // State and pipeline registers; reset abandons any in-flight miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         savedPc_q    <= 32'h0;
         ifidValid_q  <= 1'b0;
         ifidPc_q     <= 32'h0;
         ifidInst_q   <= NOP;
         missCycles_q <= 16'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         savedPc_q    <= savedPc_d;
         ifidValid_q  <= ifidValid_d;
         ifidPc_q     <= ifidPc_d;
         ifidInst_q   <= ifidInst_d;
         missCycles_q <= missCycles_d;
      end
   end

   assign ic_req      = ~rst;
   assign ic_addr     = pc_q;
   assign ifid_valid  = ifidValid_q;
   assign ifid_pc     = ifidPc_q;
   assign ifid_inst   = ifidInst_q;
   assign miss_cycles = missCycles_q;
   assign fetch_stall = ic_stall | (state_q == SQUASH);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written reset/wrap sequences,
// and a randomized run against an abstract fetch model.

module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallPc;
   logic        flushIfid;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        icReq;
   logic [31:0] icAddr;
   logic [31:0] icRdata;
   logic        icStall;
   logic        ifidValid;
   logic [31:0] ifidPc;
   logic [31:0] ifidInst;
   logic        fetchStall;
   logic [15:0] missCycles;

   int vectors     = 0;
   int miscompares = 0;

   // Abstract model: the PC, an optional parked redirect, and IF/ID contents.
   logic [31:0] mPc;
   logic        mPend;
   logic [31:0] mTarget;
   logic        mValid;
   logic [31:0] mIfPc;
   logic [31:0] mInst;
   int          mMiss;

   typedef struct {
      logic        sp;
      logic        fl;
      logic        rv;
      logic [31:0] rp;
      logic        st;
      logic [31:0] expAddr;
      logic        expFs;
      logic        expValid;
      logic [31:0] expPc;
      logic [15:0] expMiss;
   } vec_t;

   vec_t tbl[22];

   fetch_unit dut (
      .clk(clk),
      .rst(rst),
      .stall_pc(stallPc),
      .flush_ifid(flushIfid),
      .redirect_valid(redirectValid),
      .redirect_pc(redirectPc),
      .ic_req(icReq),
      .ic_addr(icAddr),
      .ic_rdata(icRdata),
      .ic_stall(icStall),
      .ifid_valid(ifidValid),
      .ifid_pc(ifidPc),
      .ifid_inst(ifidInst),
      .fetch_stall(fetchStall),
      .miss_cycles(missCycles)
   );

   // Free-running pipeline clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] instWord(input logic [31:0] a);
      return a ^ 32'h5A00_0001;
   endfunction

   // Instruction memory; while a miss is outstanding the bus carries junk.
   always_comb begin
      icRdata = icStall ? (icAddr ^ 32'hDEAD_0000) : instWord(icAddr);
   end

   function automatic vec_t mkVec(input logic sp, input logic fl, input logic rv,
                                  input logic [31:0] rp, input logic st,
                                  input logic [31:0] ea, input logic efs,
                                  input logic ev, input logic [31:0] ep,
                                  input logic [15:0] em);
      vec_t v;
      v.sp = sp; v.fl = fl; v.rv = rv; v.rp = rp; v.st = st;
      v.expAddr = ea; v.expFs = efs; v.expValid = ev; v.expPc = ep; v.expMiss = em;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic driveInputs(input logic sp, input logic fl, input logic rv,
                              input logic [31:0] rp, input logic st);
      stallPc       = sp;
      flushIfid     = fl;
      redirectValid = rv;
      redirectPc    = rp;
      icStall       = st;
   endtask

   // One table row: drive at the falling edge, check the request side
   // before the rising edge and IF/ID just after it.
   task automatic applyStimulus(input vec_t v);
      driveInputs(v.sp, v.fl, v.rv, v.rp, v.st);
      #1;
      checkOutput("ic_addr", icAddr, v.expAddr);
      checkOutput("fetch_stall", {31'b0, fetchStall}, {31'b0, v.expFs});
      @(posedge clk);
      #1;
      checkOutput("ifid_valid", {31'b0, ifidValid}, {31'b0, v.expValid});
      checkOutput("ifid_pc", ifidPc, v.expPc);
      checkOutput("ifid_inst", ifidInst, v.expValid ? instWord(v.expPc) : NOP);
      checkOutput("miss_cycles", {16'b0, missCycles}, {16'b0, v.expMiss});
      @(negedge clk);
   endtask

   task automatic modelReset();
      mPc = 32'h0; mPend = 1'b0; mTarget = 32'h0;
      mValid = 1'b0; mIfPc = 32'h0; mInst = NOP; mMiss = 0;
   endtask

   task automatic modelStep();
      if (icStall) begin
         if (mMiss < 65535) mMiss++;
         if (redirectValid) begin
            mPend   = 1'b1;
            mTarget = redirectPc;
         end
      end else if (mPend) begin
         mPc    = redirectValid ? redirectPc : mTarget;
         mValid = 1'b0;
         mInst  = NOP;
         mPend  = 1'b0;
      end else if (redirectValid) begin
         mPc    = redirectPc;
         mValid = 1'b0;
         mInst  = NOP;
      end else if (flushIfid) begin
         mPc    = mPc + 32'd4;
         mValid = 1'b0;
         mInst  = NOP;
      end else if (!stallPc) begin
         mValid = 1'b1;
         mIfPc  = mPc;
         mInst  = instWord(mPc);
         mPc    = mPc + 32'd4;
      end
   endtask

   initial begin
      //                sp fl rv rp         st  addr      fs  v  ifid_pc    miss
      tbl[0]  = mkVec(0, 0, 0, 32'h0,   0, 32'h00, 0, 1, 32'h00, 0);
      tbl[1]  = mkVec(0, 0, 0, 32'h0,   0, 32'h04, 0, 1, 32'h04, 0);
      tbl[2]  = mkVec(1, 0, 0, 32'h0,   0, 32'h08, 0, 1, 32'h04, 0);
      tbl[3]  = mkVec(1, 0, 0, 32'h0,   0, 32'h08, 0, 1, 32'h04, 0);
      tbl[4]  = mkVec(0, 0, 0, 32'h0,   0, 32'h08, 0, 1, 32'h08, 0);
      tbl[5]  = mkVec(0, 0, 1, 32'h40,  0, 32'h0C, 0, 0, 32'h08, 0);
      tbl[6]  = mkVec(0, 0, 0, 32'h0,   0, 32'h40, 0, 1, 32'h40, 0);
      tbl[7]  = mkVec(0, 1, 0, 32'h0,   0, 32'h44, 0, 0, 32'h40, 0);
      tbl[8]  = mkVec(0, 0, 0, 32'h0,   0, 32'h48, 0, 1, 32'h48, 0);
      tbl[9]  = mkVec(0, 0, 1, 32'h10,  0, 32'h4C, 0, 0, 32'h48, 0);
      tbl[10] = mkVec(0, 0, 0, 32'h0,   1, 32'h10, 1, 0, 32'h48, 1);
      tbl[11] = mkVec(0, 0, 1, 32'h80,  1, 32'h10, 1, 0, 32'h48, 2);
      tbl[12] = mkVec(0, 0, 0, 32'h0,   1, 32'h10, 1, 0, 32'h48, 3);
      tbl[13] = mkVec(0, 0, 0, 32'h0,   0, 32'h10, 1, 0, 32'h48, 3);
      tbl[14] = mkVec(0, 0, 0, 32'h0,   0, 32'h80, 0, 1, 32'h80, 3);
      tbl[15] = mkVec(0, 0, 1, 32'h100, 1, 32'h84, 1, 1, 32'h80, 4);
      tbl[16] = mkVec(0, 0, 1, 32'h90,  1, 32'h84, 1, 1, 32'h80, 5);
      tbl[17] = mkVec(0, 0, 0, 32'h0,   0, 32'h84, 1, 0, 32'h80, 5);
      tbl[18] = mkVec(0, 0, 0, 32'h0,   0, 32'h90, 0, 1, 32'h90, 5);
      tbl[19] = mkVec(0, 0, 0, 32'h0,   1, 32'h94, 1, 1, 32'h90, 6);
      tbl[20] = mkVec(0, 0, 0, 32'h0,   0, 32'h94, 0, 1, 32'h94, 6);
      tbl[21] = mkVec(0, 0, 0, 32'h0,   0, 32'h98, 0, 1, 32'h98, 6);

      rst = 1'b1;
      driveInputs(0, 0, 0, 32'h0, 0);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset ic_addr", icAddr, 32'h0);
      checkOutput("reset ic_req", {31'b0, icReq}, 32'h0);
      checkOutput("reset ifid_valid", {31'b0, ifidValid}, 32'h0);
      checkOutput("reset ifid_pc", ifidPc, 32'h0);
      checkOutput("reset ifid_inst", ifidInst, NOP);
      checkOutput("reset miss_cycles", {16'b0, missCycles}, 32'h0);
      checkOutput("reset fetch_stall", {31'b0, fetchStall}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         applyStimulus(tbl[i]);
      end

      // Reset in the middle of a miss abandons it immediately.
      driveInputs(0, 0, 0, 32'h0, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midmiss rst ic_addr", icAddr, 32'h0);
      checkOutput("midmiss rst ic_req", {31'b0, icReq}, 32'h0);
      checkOutput("midmiss rst ifid_valid", {31'b0, ifidValid}, 32'h0);
      checkOutput("midmiss rst miss_cycles", {16'b0, missCycles}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      driveInputs(0, 0, 0, 32'h0, 0);
      #1;
      checkOutput("post rst ic_addr", icAddr, 32'h0);
      checkOutput("post rst fetch_stall", {31'b0, fetchStall}, 32'h0);
      checkOutput("post rst ic_req", {31'b0, icReq}, 32'h1);

      // PC wraps from the top of the address space to zero.
      driveInputs(0, 0, 1, 32'hFFFF_FFFC, 0);
      @(posedge clk);
      #1;
      checkOutput("wrap bubble valid", {31'b0, ifidValid}, 32'h0);
      @(negedge clk);
      driveInputs(0, 0, 0, 32'h0, 0);
      #1;
      checkOutput("wrap ic_addr top", icAddr, 32'hFFFF_FFFC);
      @(posedge clk);
      #1;
      checkOutput("wrap ifid_pc", ifidPc, 32'hFFFF_FFFC);
      checkOutput("wrap ifid_inst", ifidInst, instWord(32'hFFFF_FFFC));
      @(negedge clk);
      #1;
      checkOutput("wrap ic_addr zero", icAddr, 32'h0);

      // Randomized run against the abstract model.
      @(negedge clk);
      rst = 1'b1;
      driveInputs(0, 0, 0, 32'h0, 0);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      for (int n = 0; n < 600; n++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         driveInputs($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
                     $urandom_range(0, 9) < 2, tgt, $urandom_range(0, 9) < 3);
         #1;
         checkOutput("rand ic_addr", icAddr, mPc);
         checkOutput("rand fetch_stall", {31'b0, fetchStall}, {31'b0, icStall | mPend});
         checkOutput("rand ic_req", {31'b0, icReq}, 32'h1);
         @(posedge clk);
         modelStep();
         #1;
         checkOutput("rand ifid_valid", {31'b0, ifidValid}, {31'b0, mValid});
         if (mValid) begin
            checkOutput("rand ifid_pc", ifidPc, mIfPc);
         end
         checkOutput("rand ifid_inst", ifidInst, mInst);
         checkOutput("rand miss_cycles", {16'b0, missCycles}, 32'(mMiss));
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC register, drives the instruction-cache request, and loads the IF/ID pipeline register. It is the consumer of the hazard unit's stall, flush and branch-redirect outputs. It also absorbs I-cache miss latency: a redirect that arrives mid-miss is deferred, the late instruction is discarded, and fetch resumes at the saved target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP, 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0)

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_pc  in  1  from hazard unit; hold PC and IF/ID contents
- flush_ifid  in  1  from hazard unit; replace IF/ID with a bubble
- redirect_valid  in  1  taken branch/jump resolved; take redirect_pc
- redirect_pc  in  32  redirect target, word-aligned
- ic_req  out  1  I-cache read request
- ic_addr  out  32  I-cache word address (PC)
- ic_rdata  in  32  instruction; valid in any cycle with ic_req=1 and ic_stall=0
- ic_stall  in  1  I-cache miss in progress; ic_addr must stay stable
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pc  out  32  PC of the IF/ID instruction
- ifid_inst  out  32  IF/ID instruction word
- fetch_stall  out  1  IF cannot deliver this cycle; pipeline control freezes younger stages
- miss_cycles  out  16  count of cycles with ic_stall=1; saturates at 16'hFFFF

## Operation
- States: FETCH, WAIT (miss, no pending redirect), SQUASH (miss with a saved redirect).
- Reset values:
  - state=FETCH, pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_inst=NOP, miss_cycles=0.
  - Saved target register = 0.
- ic_req=1 in every state while rst=0; ic_addr=pc.
- FETCH, ic_stall=0, priority redirect > flush_ifid > stall_pc:
  - redirect_valid=1: pc<=redirect_pc; IF/ID<=bubble (valid=0, inst=NOP, pc unchanged).
  - flush_ifid=1 (no redirect): pc<=pc+4; IF/ID<=bubble.
  - stall_pc=1 (no redirect, no flush): pc and IF/ID hold; the fetched word is dropped and re-fetched next cycle.
  - Otherwise: IF/ID<={1, pc, ic_rdata}; pc<=pc+4.
- FETCH, ic_stall=1:
  - redirect_valid=1: save redirect_pc, go to SQUASH.
  - Otherwise: go to WAIT.
  - In both cases pc holds.
- WAIT:
  - pc holds.
  - redirect_valid=1 while ic_stall=1: save the target, go to SQUASH.
  - ic_stall=0: apply the FETCH ic_stall=0 rules in that cycle (same priorities), then go to FETCH.
- SQUASH:
  - pc holds until ic_stall=0.
  - A further redirect_valid overwrites the saved target (youngest wins).
  - On ic_stall=0: discard ic_rdata, pc<=saved target, IF/ID<=bubble, go to FETCH.
  - A redirect_valid in that same cycle takes precedence over the saved target.
- fetch_stall = ic_stall | (state==SQUASH).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- stall_pc does not block redirect or flush; the hazard unit guarantees redirect and load-use stall never need to coexist for the same instruction.
- rst asserted mid-miss: state→FETCH and all registers reset at once; the in-flight I-cache response is ignored.

## Timing
- Hit path: instruction at pc is visible on ifid_* one clk after the request cycle (1-cycle IF latency).
- Miss of N stall cycles: the instruction appears in IF/ID at the edge ending the first ic_stall=0 cycle, N+1 cycles after the request.
- Redirect on a hit: target is on ic_addr the cycle after redirect_valid; the first target instruction is in IF/ID 2 cycles after redirect_valid.
- Redirect during a miss: the target is on ic_addr the cycle after ic_stall falls.
- miss_cycles increments on each edge where ic_stall=1 and rst=0.

## Test plan
- Reset then straight-line, no misses: after rst falls, ic_addr = 0,4,8 on consecutive cycles; ifid_pc = 0,4,8 one cycle later, each with ifid_valid=1.
- stall_pc high for 2 cycles at pc=8: ic_addr stays 8 for 3 cycles; ifid_pc stays 4 and ifid_inst is unchanged.
- Redirect on hit, pc=C, redirect_pc=40: next ic_addr=40; IF/ID is a bubble (valid=0, inst=13); then ifid_pc=40.
- Miss of 3 cycles at pc=10 with a redirect to 80 during the second stall cycle:
  - fetch_stall=1 for 4 cycles, the last one in SQUASH with ic_stall=0; word at 10 never enters IF/ID.
  - Next ic_addr=80; miss_cycles increases by 3.
- Two redirects during one miss (to 80, then to 90): fetch resumes at 90.
- rst asserted during a miss: ic_addr returns to RESET_PC immediately; ifid_valid=0; miss_cycles=0.
